// File: rtl/rds_block_sync_if.sv
// Symbol-in / block-out bundle for the RDS block synchroniser.
// With RDS_GROUP_EN defined the bundle also carries the assembled 64-bit group.
interface rds_block_sync_if;
   logic        sym_in;
   logic        sym_valid;
   logic [15:0] data_out;
   logic [2:0]  block_id;
   logic        block_valid;
   logic        block_err;
   logic        synced;
`ifdef RDS_GROUP_EN
   logic [63:0] group_out;
   logic        group_valid;
`endif

   modport master (
      output sym_in, sym_valid,
      input  data_out, block_id, block_valid, block_err, synced
`ifdef RDS_GROUP_EN
      , group_out, group_valid
`endif
   );

   modport slave (
      input  sym_in, sym_valid,
      output data_out, block_id, block_valid, block_err, synced
`ifdef RDS_GROUP_EN
      , group_out, group_valid
`endif
   );
endinterface

// File: rtl/rds_block_sync.sv
// RDS block synchroniser: differential decode, offset-word block lock, A/B/C/C'/D tracking.
// Optional RDS_GROUP_EN adds full-group assembly (group_out/group_valid).
module rds_block_sync #(
   parameter int unsigned c_sync_confirm   = 1,
   parameter int unsigned c_bad_blocks_max = 8
) (
   input  logic           clk,
   input  logic           reset,
   rds_block_sync_if.slave bus
);

   typedef enum logic [1:0] {st_search, st_presync, st_sync} state_t;

   localparam logic [2:0] c_confirm_cnt = 3'(c_sync_confirm);
   localparam logic [3:0] c_bad_cnt_max = 4'(c_bad_blocks_max);

   // Syndrome of 16 data bits for g(x)=x^10+x^8+x^7+x^5+x^4+x^3+1, unrolled per bit.
   function automatic logic [9:0] crc10(input logic [15:0] d);
      logic [9:0] c;
      logic       fb;
      c = 10'd0;
      for (int i = 15; i >= 0; i--) begin
         fb = d[i] ^ c[9];
         c  = {c[8:0], 1'b0} ^ (fb ? 10'h1B9 : 10'h000);
      end
      return c;
   endfunction

   function automatic logic [3:0] offset_lookup(input logic [9:0] off);
      case (off)
         10'h0FC: return {1'b1, 3'd0};
         10'h198: return {1'b1, 3'd1};
         10'h168: return {1'b1, 3'd2};
         10'h350: return {1'b1, 3'd3};
         10'h1B4: return {1'b1, 3'd4};
         default: return {1'b0, 3'd0};
      endcase
   endfunction

   function automatic logic [1:0] id_to_pos(input logic [2:0] id);
      case (id)
         3'd0:    return 2'd0;
         3'd1:    return 2'd1;
         3'd2,
         3'd3:    return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   state_t      state_r, state_nxt;
   logic        prev_sym_r;
   logic [25:0] w_r;
   logic [4:0]  bit_cnt_r, bit_cnt_nxt;
   logic [1:0]  pos_r, pos_nxt;
   logic [2:0]  good_cnt_r, good_cnt_nxt;
   logic [3:0]  bad_cnt_r, bad_cnt_nxt;
   logic [15:0] data_out_r, data_nxt;
   logic [2:0]  block_id_r, id_nxt;
   logic        block_valid_r, valid_nxt;
   logic        block_err_r, err_nxt;
   logic        synced_r, synced_nxt;

   logic        bit_s;
   logic [25:0] w_s;
   logic [3:0]  lookup_s;
   logic        hit_s;
   logic [2:0]  hit_id_s;
   logic [1:0]  hit_pos_s;
   logic        match_s;
   logic        boundary_s;

   // The window is tested with the incoming bit already shifted in, so a decision needs no extra cycle.
   assign bit_s      = bus.sym_in ^ prev_sym_r;
   assign w_s        = {w_r[24:0], bit_s};
   assign lookup_s   = offset_lookup(w_s[9:0] ^ crc10(w_s[25:10]));
   assign hit_s      = lookup_s[3];
   assign hit_id_s   = lookup_s[2:0];
   assign hit_pos_s  = id_to_pos(hit_id_s);
   assign match_s    = hit_s && (hit_pos_s == pos_r);
   assign boundary_s = (bit_cnt_r == 5'd25);

   // Next-state and output decisions for search / presync / sync.
   always_comb begin
      state_nxt    = state_r;
      bit_cnt_nxt  = bit_cnt_r;
      pos_nxt      = pos_r;
      good_cnt_nxt = good_cnt_r;
      bad_cnt_nxt  = bad_cnt_r;
      data_nxt     = data_out_r;
      id_nxt       = block_id_r;
      valid_nxt    = 1'b0;
      err_nxt      = 1'b0;
      synced_nxt   = synced_r;
      if (bus.sym_valid) begin
         bit_cnt_nxt = boundary_s ? 5'd0 : bit_cnt_r + 5'd1;
         case (state_r)
            st_search: begin
               bit_cnt_nxt = 5'd0;
               if (hit_s) begin
                  pos_nxt      = hit_pos_s + 2'd1;
                  good_cnt_nxt = 3'd0;
                  state_nxt    = st_presync;
               end else begin
                  state_nxt = st_search;
               end
            end
            st_presync: begin
               if (boundary_s && match_s) begin
                  good_cnt_nxt = good_cnt_r + 3'd1;
                  pos_nxt      = pos_r + 2'd1;
                  if (good_cnt_nxt == c_confirm_cnt) begin
                     state_nxt   = st_sync;
                     synced_nxt  = 1'b1;
                     bad_cnt_nxt = 4'd0;
                     valid_nxt   = 1'b1;
                     data_nxt    = w_s[25:10];
                     id_nxt      = hit_id_s;
                  end else begin
                     state_nxt = st_presync;
                  end
               end else if (boundary_s) begin
                  state_nxt = st_search;
               end else begin
                  state_nxt = st_presync;
               end
            end
            st_sync: begin
               if (boundary_s) begin
                  // Flywheel: the expected position advances whether or not the block checked out.
                  pos_nxt = pos_r + 2'd1;
                  if (match_s) begin
                     valid_nxt   = 1'b1;
                     data_nxt    = w_s[25:10];
                     id_nxt      = hit_id_s;
                     bad_cnt_nxt = 4'd0;
                  end else begin
                     err_nxt     = 1'b1;
                     bad_cnt_nxt = bad_cnt_r + 4'd1;
                     if (bad_cnt_nxt == c_bad_cnt_max) begin
                        synced_nxt = 1'b0;
                        state_nxt  = st_search;
                     end else begin
                        state_nxt = st_sync;
                     end
                  end
               end else begin
                  state_nxt = st_sync;
               end
            end
            default: begin
               state_nxt  = st_search;
               synced_nxt = 1'b0;
            end
         endcase
      end else begin
         state_nxt = state_r;
      end
   end

   // State, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= st_search;
         prev_sym_r    <= 1'b0;
         w_r           <= 26'd0;
         bit_cnt_r     <= 5'd0;
         pos_r         <= 2'd0;
         good_cnt_r    <= 3'd0;
         bad_cnt_r     <= 4'd0;
         data_out_r    <= 16'd0;
         block_id_r    <= 3'd0;
         block_valid_r <= 1'b0;
         block_err_r   <= 1'b0;
         synced_r      <= 1'b0;
      end else begin
         state_r       <= state_nxt;
         bit_cnt_r     <= bit_cnt_nxt;
         pos_r         <= pos_nxt;
         good_cnt_r    <= good_cnt_nxt;
         bad_cnt_r     <= bad_cnt_nxt;
         data_out_r    <= data_nxt;
         block_id_r    <= id_nxt;
         block_valid_r <= valid_nxt;
         block_err_r   <= err_nxt;
         synced_r      <= synced_nxt;
         if (bus.sym_valid) begin
            prev_sym_r <= bus.sym_in;
            w_r        <= w_s;
         end
      end
   end

   assign bus.data_out    = data_out_r;
   assign bus.block_id    = block_id_r;
   assign bus.block_valid = block_valid_r;
   assign bus.block_err   = block_err_r;
   assign bus.synced      = synced_r;

`ifdef RDS_GROUP_EN
   logic [47:0] grp_r, grp_nxt;
   logic [2:0]  flags_r, flags_nxt;
   logic [63:0] group_out_r, gout_nxt;
   logic        group_valid_r, gvalid_nxt;

   // Collect A/B/C of the current group; flags drop on any bad block or loss of sync.
   always_comb begin
      grp_nxt    = grp_r;
      flags_nxt  = flags_r;
      gout_nxt   = group_out_r;
      gvalid_nxt = 1'b0;
      if (valid_nxt) begin
         case (pos_r)
            2'd0: begin
               grp_nxt[47:32] = w_s[25:10];
               flags_nxt      = 3'b001;
            end
            2'd1: begin
               grp_nxt[31:16] = w_s[25:10];
               flags_nxt[1]   = 1'b1;
            end
            2'd2: begin
               grp_nxt[15:0] = w_s[25:10];
               flags_nxt[2]  = 1'b1;
            end
            default: begin
               flags_nxt = 3'b000;
               if (&flags_r) begin
                  gout_nxt   = {grp_r, w_s[25:10]};
                  gvalid_nxt = 1'b1;
               end else begin
                  gout_nxt = group_out_r;
               end
            end
         endcase
      end else if (err_nxt || !synced_nxt) begin
         flags_nxt = 3'b000;
      end else begin
         flags_nxt = flags_r;
      end
   end

   // Group storage and registered group outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         grp_r         <= 48'd0;
         flags_r       <= 3'b000;
         group_out_r   <= 64'd0;
         group_valid_r <= 1'b0;
      end else begin
         grp_r         <= grp_nxt;
         flags_r       <= flags_nxt;
         group_out_r   <= gout_nxt;
         group_valid_r <= gvalid_nxt;
      end
   end

   assign bus.group_out   = group_out_r;
   assign bus.group_valid = group_valid_r;
`endif

endmodule

// File: tb/tb_rds_block_sync.sv
// Directed bench for rds_block_sync: encodes RDS blocks with a reference checkword model,
// applies a vector table of blocks, then hand-written reset / misaligned-start sequences.
module tb_rds_block_sync;

   localparam logic [9:0] off_a  = 10'h0FC;
   localparam logic [9:0] off_b  = 10'h198;
   localparam logic [9:0] off_c  = 10'h168;
   localparam logic [9:0] off_cp = 10'h350;
   localparam logic [9:0] off_d  = 10'h1B4;

   typedef struct {
      logic [15:0] data;
      logic [9:0]  off;
      logic        flip;
      logic [4:0]  fidx;
      logic        ev;
      logic        ee;
      logic        es;
      logic [15:0] ed;
      logic [2:0]  eid;
      logic        egv;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic tx_prev;
   int   n_checks = 0;
   int   n_errors = 0;
   int   bv_cnt = 0;
   int   be_cnt = 0;
   vec_t vt[20];

   always #5 clk = ~clk;

   rds_block_sync_if bus ();

   rds_block_sync #(.c_sync_confirm(1), .c_bad_blocks_max(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(negedge clk) begin
      if (bus.block_valid === 1'b1) bv_cnt <= bv_cnt + 1;
      if (bus.block_err === 1'b1) be_cnt <= be_cnt + 1;
   end

   // Polynomial long division of data*x^10 by x^10+x^8+x^7+x^5+x^4+x^3+1.
   function automatic logic [9:0] ref_check(input logic [15:0] d);
      logic [25:0] r;
      r = {d, 10'd0};
      for (int i = 25; i >= 10; i--)
         if (r[i]) r[i -: 11] = r[i -: 11] ^ 11'b10110111001;
      return r[9:0];
   endfunction

   function automatic logic [15:0] data_for_id(input logic [2:0] id);
      case (id)
         3'd0:    return 16'h1234;
         3'd1:    return 16'h0408;
         3'd2,
         3'd3:    return 16'hE0CD;
         default: return 16'h4142;
      endcase
   endfunction

   task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic tx_bit(input logic b);
      tx_prev       = tx_prev ^ b;
      bus.sym_in    = tx_prev;
      bus.sym_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic tx_block(input logic [15:0] data, input logic [9:0] off, input logic flip, input logic [4:0] fidx);
      logic [25:0] word;
      word = {data, ref_check(data) ^ off};
      if (flip) word[fidx] = ~word[fidx];
      for (int i = 25; i >= 0; i--) tx_bit(word[i]);
   endtask

   task automatic idle(input int n);
      bus.sym_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.sym_valid = ~bus.sym_valid;
         bus.sym_in    = ~bus.sym_in;
         @(posedge clk);
         #1;
      end
      reset         = 1'b0;
      bus.sym_valid = 1'b0;
      bus.sym_in    = 1'b0;
      tx_prev       = 1'b0;
   endtask

   initial begin
      int emitted;
      logic [6:0] prefix;

      //        data      off     flip  fidx   ev    ee    es    ed        eid   egv
      vt[0]  = '{16'h1234, off_a,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
      vt[1]  = '{16'h0408, off_b,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'h0408, 3'd1, 1'b0};
      vt[2]  = '{16'hE0CD, off_c,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'hE0CD, 3'd2, 1'b0};
      vt[3]  = '{16'h4142, off_d,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[4]  = '{16'h1234, off_a,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'h1234, 3'd0, 1'b0};
      vt[5]  = '{16'h0408, off_b,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'h0408, 3'd1, 1'b0};
      vt[6]  = '{16'hE0CD, off_c,  1'b1, 5'd5,  1'b0, 1'b1, 1'b1, 16'h0408, 3'd1, 1'b0};
      vt[7]  = '{16'h4142, off_d,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[8]  = '{16'h1234, off_a,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'h1234, 3'd0, 1'b0};
      vt[9]  = '{16'h0408, off_b,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'h0408, 3'd1, 1'b0};
      vt[10] = '{16'hE0CD, off_cp, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'hE0CD, 3'd3, 1'b0};
      vt[11] = '{16'h4142, off_d,  1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 16'h4142, 3'd4, 1'b1};
      // Clean B where A is expected, then seven corrupted blocks: sync drops on the 8th error.
      vt[12] = '{16'h0408, off_b,  1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[13] = '{16'h0408, off_b,  1'b1, 5'd0,  1'b0, 1'b1, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[14] = '{16'hE0CD, off_c,  1'b1, 5'd12, 1'b0, 1'b1, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[15] = '{16'h4142, off_d,  1'b1, 5'd25, 1'b0, 1'b1, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[16] = '{16'h1234, off_a,  1'b1, 5'd3,  1'b0, 1'b1, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[17] = '{16'h0408, off_b,  1'b1, 5'd20, 1'b0, 1'b1, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[18] = '{16'hE0CD, off_c,  1'b1, 5'd9,  1'b0, 1'b1, 1'b1, 16'h4142, 3'd4, 1'b0};
      vt[19] = '{16'h4142, off_d,  1'b1, 5'd17, 1'b0, 1'b1, 1'b0, 16'h4142, 3'd4, 1'b0};

      reset         = 1'b1;
      bus.sym_in    = 1'b0;
      bus.sym_valid = 1'b0;
      tx_prev       = 1'b0;
      pulse_reset(3);
      check("reset data_out", 0, bus.data_out, 16'h0000);
      check("reset block_id", 0, bus.block_id, 3'd0);
      check("reset block_valid", 0, bus.block_valid, 1'b0);
      check("reset block_err", 0, bus.block_err, 1'b0);
      check("reset synced", 0, bus.synced, 1'b0);

      for (int i = 0; i < 104; i++) tx_bit(1'b0);
      check("idle synced", 0, bus.synced, 1'b0);
      check("idle pulses", 0, bv_cnt + be_cnt, 0);

      for (int i = 0; i < 20; i++) begin
         tx_block(vt[i].data, vt[i].off, vt[i].flip, vt[i].fidx);
         check("vec block_valid", i, bus.block_valid, vt[i].ev);
         check("vec block_err", i, bus.block_err, vt[i].ee);
         check("vec synced", i, bus.synced, vt[i].es);
         check("vec data_out", i, bus.data_out, vt[i].ed);
         check("vec block_id", i, bus.block_id, vt[i].eid);
`ifdef RDS_GROUP_EN
         check("vec group_valid", i, bus.group_valid, vt[i].egv);
         if (vt[i].egv) check("vec group_out", i, bus.group_out, 64'h12340408E0CD4142);
`endif
      end
      idle(2);

      // Reset in the middle of a block, then a clean stream must lock by the end of B.
      for (int i = 0; i < 10; i++) tx_bit(1'b1);
      pulse_reset(1);
      check("midreset synced", 0, bus.synced, 1'b0);
      check("midreset data_out", 0, bus.data_out, 16'h0000);
      tx_block(16'h1234, off_a, 1'b0, 5'd0);
      check("resync A valid", 0, bus.block_valid, 1'b0);
      tx_block(16'h0408, off_b, 1'b0, 5'd0);
      check("resync B synced", 0, bus.synced, 1'b1);
      check("resync B valid", 0, bus.block_valid, 1'b1);
      check("resync B data", 0, bus.data_out, 16'h0408);
      tx_block(16'hE0CD, off_c, 1'b0, 5'd0);
      check("resync C data", 0, bus.data_out, 16'hE0CD);
      check("resync C id", 0, bus.block_id, 3'd2);
      idle(2);
      check("block_valid pulses", 0, bv_cnt, 12);
      check("block_err pulses", 0, be_cnt, 9);

      // Misaligned start: seven filler bits, then two groups with sym_valid every cycle.
      pulse_reset(1);
      prefix  = 7'b1011001;
      emitted = 0;
      for (int i = 6; i >= 0; i--) tx_bit(prefix[i]);
      for (int g = 0; g < 2; g++) begin
         for (int b = 0; b < 4; b++) begin
            case (b)
               0:       tx_block(16'h1234, off_a, 1'b0, 5'd0);
               1:       tx_block(16'h0408, off_b, 1'b0, 5'd0);
               2:       tx_block(16'hE0CD, off_c, 1'b0, 5'd0);
               default: tx_block(16'h4142, off_d, 1'b0, 5'd0);
            endcase
            if (bus.block_valid === 1'b1) begin
               emitted++;
               check("prefix data_out", b, bus.data_out, data_for_id(bus.block_id));
               check("prefix block_id", b, bus.block_id, (b == 3) ? 3'd4 : 3'(b));
            end
         end
      end
      check("prefix synced", 0, bus.synced, 1'b1);
      check("prefix emissions", 0, (emitted >= 5) ? 1 : 0, 1);
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
